filter_row_engine: RTL and testbench

Parametrised row-oriented pixel filter engine for the filter-processor datapath. Given a start command, it streams an IMG_W × IMG_H image from RAM over a single-port read/write interface and writes one filtered pixel per source pixel to a destination region. It supports four modes: pass-through, invert, threshold and a 3-tap horizontal blur with edge replication. It generalises the fixed 8-bit RAM path of the processor to configurable pixel width, address width and image geometry.

---
 rtl/filter_pkg.sv | 17 +
 rtl/filter_kernel.sv | 35 +++
 rtl/filter_row_engine.sv | 190 +++++++++++++++++++
 tb/tb_filter_row_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - mode encodings and FSM state type for filter_row_engine
package filter_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_THR  = 2'd2;
    localparam logic [1:0] MODE_BLUR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/filter_kernel.sv
// rtl/filter_kernel.sv - combinational pixel kernel f(a,b,c); blur path only with FILTER_BLUR_EN
module filter_kernel
    import filter_pkg::*;
#(
    parameter int DATA_W = 8
) (
`ifdef FILTER_BLUR_EN
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] c_i,
`endif
    input  logic [DATA_W-1:0] b_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] thr_i,
    output logic [DATA_W-1:0] pix_o
);

`ifdef FILTER_BLUR_EN
    // Two guard bits keep a+2b+c exact; the >>2 result always fits DATA_W.
    logic [DATA_W+1:0] sum;
    assign sum = {2'b00, a_i} + {1'b0, b_i, 1'b0} + {2'b00, c_i};
`endif

    always_comb begin
        pix_o = b_i;
        case (mode_i)
            MODE_INV: pix_o = ~b_i;
            MODE_THR: pix_o = (b_i >= thr_i) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
`ifdef FILTER_BLUR_EN
            MODE_BLUR: pix_o = sum[DATA_W+1:2];
`endif
            default: pix_o = b_i;
        endcase
    end

endmodule

// File: rtl/filter_row_engine.sv
// rtl/filter_row_engine.sv - row-streaming pixel filter over a single-port RAM; FILTER_BLUR_EN enables 3-tap blur
module filter_row_engine
    import filter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [DATA_W-1:0] threshold,
    output logic              busy,
    output logic              done,
    output logic              mem_RE_RAM,
    output logic              mem_WE_RAM,
    output logic [ADDR_W-1:0] Data_Dir_RAM,
    output logic [DATA_W-1:0] Data_RAM,
    input  logic [DATA_W-1:0] Data_in_RAM
);

    localparam int KW = $clog2(IMG_W);
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [KW-1:0]     K_LAST   = KW'(IMG_W - 1);
    localparam logic [RW-1:0]     R_LAST   = RW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [RW-1:0]     row_q, row_d;
    logic [ADDR_W-1:0] row_off_q, row_off_d;
    logic              tail_q, tail_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [DATA_W-1:0] thr_q, thr_d;
    logic [DATA_W-1:0] b_q, b_d, c_q, c_d;
    logic [DATA_W-1:0] kern_pix;
    logic [KW-1:0]     wr_col;
`ifdef FILTER_BLUR_EN
    logic [DATA_W-1:0] a_q, a_d;
`endif

    filter_kernel #(.DATA_W(DATA_W)) u_kernel (
`ifdef FILTER_BLUR_EN
        .a_i    (a_q),
        .c_i    (c_q),
`endif
        .b_i    (b_q),
        .mode_i (mode_q),
        .thr_i  (thr_q),
        .pix_o  (kern_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            row_q     <= '0;
            row_off_q <= '0;
            tail_q    <= 1'b0;
            mode_q    <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            thr_q     <= '0;
            b_q       <= '0;
            c_q       <= '0;
`ifdef FILTER_BLUR_EN
            a_q       <= '0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            row_q     <= row_d;
            row_off_q <= row_off_d;
            tail_q    <= tail_d;
            mode_q    <= mode_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            thr_q     <= thr_d;
            b_q       <= b_d;
            c_q       <= c_d;
`ifdef FILTER_BLUR_EN
            a_q       <= a_d;
`endif
        end
    end

    // Normal writes trail the read column by one; the tail write lands on the last column itself.
    assign wr_col = tail_q ? k_q : (k_q - KW'(1));

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        row_d        = row_q;
        row_off_d    = row_off_q;
        tail_d       = tail_q;
        mode_d       = mode_q;
        src_d        = src_q;
        dst_d        = dst_q;
        thr_d        = thr_q;
        b_d          = b_q;
        c_d          = c_q;
`ifdef FILTER_BLUR_EN
        a_d          = a_q;
`endif
        busy         = (state_q != ST_IDLE);
        done         = 1'b0;
        mem_RE_RAM   = 1'b0;
        mem_WE_RAM   = 1'b0;
        Data_Dir_RAM = '0;
        Data_RAM     = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    src_d     = src_base;
                    dst_d     = dst_base;
                    thr_d     = threshold;
                    k_d       = '0;
                    row_d     = '0;
                    row_off_d = '0;
                    tail_d    = 1'b0;
                    state_d   = ST_RD;
                end
            end
            ST_RD: begin
                mem_RE_RAM   = 1'b1;
                Data_Dir_RAM = src_q + row_off_q + ADDR_W'(k_q);
                state_d      = ST_CAP;
            end
            ST_CAP: begin
                if (k_q == '0) begin
                    // First pixel of a row fills the whole window: left-edge replication.
`ifdef FILTER_BLUR_EN
                    a_d = Data_in_RAM;
`endif
                    b_d     = Data_in_RAM;
                    c_d     = Data_in_RAM;
                    k_d     = KW'(1);
                    state_d = ST_RD;
                end else begin
`ifdef FILTER_BLUR_EN
                    a_d = b_q;
`endif
                    b_d     = c_q;
                    c_d     = Data_in_RAM;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                mem_WE_RAM   = 1'b1;
                Data_Dir_RAM = dst_q + row_off_q + ADDR_W'(wr_col);
                Data_RAM     = kern_pix;
                if (tail_q) begin
                    tail_d = 1'b0;
                    k_d    = '0;
                    if (row_q == R_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d     = row_q + RW'(1);
                        row_off_d = row_off_q + ROW_STEP;
                        state_d   = ST_RD;
                    end
                end else if (k_q != K_LAST) begin
                    k_d     = k_q + KW'(1);
                    state_d = ST_RD;
                end else begin
                    // Shift without a new read so the window becomes (b,c,c): right-edge replication.
                    tail_d = 1'b1;
`ifdef FILTER_BLUR_EN
                    a_d = b_q;
`endif
                    b_d     = c_q;
                    state_d = ST_WR;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_filter_row_engine.sv
// tb/tb_filter_row_engine.sv - scoreboard bench for filter_row_engine (4x2 image, 8-bit pixels)
module tb_filter_row_engine;

    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;
    localparam int JOB_CYCLES = 3 * W * H + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [DW-1:0] threshold = '0;
    logic          busy, done, re, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_data [$];
    int checks = 0;
    int errors = 0;

    filter_row_engine #(.DATA_W(DW), .ADDR_W(AW), .IMG_W(W), .IMG_H(H)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode         (mode),
        .src_base     (src_base),
        .dst_base     (dst_base),
        .threshold    (threshold),
        .busy         (busy),
        .done         (done),
        .mem_RE_RAM   (re),
        .mem_WE_RAM   (we),
        .Data_Dir_RAM (addr),
        .Data_RAM     (wdata),
        .Data_in_RAM  (rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (re) rdata <= mem[addr];
    end

    function automatic logic [DW-1:0] model(input logic [1:0] m, input logic [DW-1:0] l,
                                            input logic [DW-1:0] c, input logic [DW-1:0] r,
                                            input logic [DW-1:0] t);
        int s;
        case (m)
            2'd1: s = 255 - int'(c);
            2'd2: s = (c >= t) ? 255 : 0;
`ifdef FILTER_BLUR_EN
            2'd3: s = (int'(l) + 2 * int'(c) + int'(r)) / 4;
`endif
            default: s = int'(c);
        endcase
        return DW'(s);
    endfunction

    // Advance one cycle and consume any write against the scoreboard.
    task automatic tick();
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        checks++;
        if (re && we) begin
            errors++;
            $display("FAIL re_we_overlap re=%0b we=%0b required not both", re, we);
        end
        if (we) begin
            checks++;
            if (exp_addr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h required no write", addr, wdata);
            end else begin
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                if (addr !== ea) begin
                    errors++;
                    $display("FAIL wr_addr got %h required %h", addr, ea);
                end
                checks++;
                if (wdata !== ed) begin
                    errors++;
                    $display("FAIL wr_data at %h got %h required %h", ea, wdata, ed);
                end
            end
        end
    endtask

    task automatic launch(input logic [1:0] m, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input logic [DW-1:0] thr, input logic [DW-1:0] pix [NPIX]);
        int l, r;
        for (int i = 0; i < NPIX; i++) mem[src + AW'(i)] = pix[i];
        for (int row = 0; row < H; row++) begin
            for (int j = 0; j < W; j++) begin
                l = (j == 0) ? 0 : j - 1;
                r = (j == W - 1) ? W - 1 : j + 1;
                exp_addr.push_back(dst + AW'(row * W + j));
                exp_data.push_back(model(m, pix[row*W+l], pix[row*W+j], pix[row*W+r], thr));
            end
        end
        mode = m;
        src_base = src;
        dst_base = dst;
        threshold = thr;
        start = 1'b1;
    endtask

    // Runs until busy drops; poke>0 pulses a disturbing start with altered inputs on that cycle.
    task automatic wait_job(input int poke, output int bcnt, output int dcnt, output int dpos);
        bit fin;
        fin = 0;
        bcnt = 0;
        dcnt = 0;
        dpos = 0;
        for (int n = 1; n <= 200 && !fin; n++) begin
            tick();
            if (n == poke) begin
                start = 1'b1;
                mode = ~mode;
                src_base = src_base + AW'(7);
                threshold = ~threshold;
            end else begin
                start = 1'b0;
            end
            if (!busy) begin
                fin = 1;
            end else begin
                bcnt++;
                if (done) begin
                    dcnt++;
                    dpos = n;
                end
            end
        end
        start = 1'b0;
        if (!fin) begin
            errors++;
            $display("FAIL job_timeout busy still high after 200 cycles");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 6;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b required 0", done); end
        if (re !== 1'b0) begin errors++; $display("FAIL rst_re got %b required 0", re); end
        if (we !== 1'b0) begin errors++; $display("FAIL rst_we got %b required 0", we); end
        if (addr !== '0) begin errors++; $display("FAIL rst_addr got %h required 0", addr); end
        if (wdata !== '0) begin errors++; $display("FAIL rst_data got %h required 0", wdata); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_and_check(input string name, input int poke);
        int bcnt, dcnt, dpos;
        wait_job(poke, bcnt, dcnt, dpos);
        checks += 4;
        if (bcnt != JOB_CYCLES) begin errors++; $display("FAIL %s busy_cycles got %0d required %0d", name, bcnt, JOB_CYCLES); end
        if (dcnt != 1) begin errors++; $display("FAIL %s done_count got %0d required 1", name, dcnt); end
        if (dpos != JOB_CYCLES) begin errors++; $display("FAIL %s done_cycle got %0d required %0d", name, dpos, JOB_CYCLES); end
        if (exp_addr.size() != 0) begin
            errors++;
            $display("FAIL %s missing_writes got %0d left required 0", name, exp_addr.size());
            exp_addr.delete();
            exp_data.delete();
        end
        tick();
    endtask

    task automatic test_blur();
        logic [DW-1:0] px [NPIX];
        px = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd200, 8'd255, 8'd255, 8'd3};
        launch(2'd3, 16'h0100, 16'h1000, 8'h00, px);
        run_and_check("blur", 0);
    endtask

    task automatic test_row_boundary();
        logic [DW-1:0] px [NPIX];
        px = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd100, 8'd0, 8'd0, 8'd0};
        launch(2'd3, 16'h0200, 16'h2000, 8'h00, px);
        run_and_check("row_boundary", 0);
    endtask

    task automatic test_invert();
        logic [DW-1:0] px [NPIX];
        px = '{8'h10, 8'h00, 8'hFF, 8'h5A, 8'h01, 8'h80, 8'h7F, 8'hEF};
        launch(2'd1, 16'h0300, 16'h3000, 8'h00, px);
        run_and_check("invert", 0);
    endtask

    task automatic test_threshold();
        logic [DW-1:0] px [NPIX];
        px = '{8'h7F, 8'h80, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h80, 8'h01};
        launch(2'd2, 16'h0400, 16'h4000, 8'h80, px);
        run_and_check("threshold", 0);
    endtask

    task automatic test_start_ignored();
        logic [DW-1:0] px [NPIX];
        for (int i = 0; i < NPIX; i++) px[i] = DW'($urandom_range(0, 255));
        launch(2'd0, 16'hFFFC, 16'h5000, 8'h40, px);
        run_and_check("start_ignored", 9);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] px [NPIX];
        bit hit;
        hit = 0;
        px = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd1, 8'd2, 8'd3, 8'd4};
        launch(2'd3, 16'h0600, 16'h6000, 8'h00, px);
        for (int n = 0; n < 100 && !hit; n++) begin
            tick();
            start = 1'b0;
            if (we && addr == 16'h6002) hit = 1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rstmid_no_wr_col2 got none required write to 6002"); end
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b required 0", busy); end
        if (we !== 1'b0) begin errors++; $display("FAIL rstmid_we got %b required 0", we); end
        if (re !== 1'b0) begin errors++; $display("FAIL rstmid_re got %b required 0", re); end
        if (addr !== '0) begin errors++; $display("FAIL rstmid_addr got %h required 0", addr); end
        if (wdata !== '0) begin errors++; $display("FAIL rstmid_data got %h required 0", wdata); end
        exp_addr.delete();
        exp_data.delete();
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b required 0", done); end
        end
        rst_n = 1'b1;
        tick();
        launch(2'd3, 16'h0600, 16'h6100, 8'h00, px);
        run_and_check("after_reset", 0);
    endtask

    initial begin
        test_reset();
        test_blur();
        test_row_boundary();
        test_invert();
        test_threshold();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
